usb_desc_reader: RTL

USB_DESC_READER -- requirements
Module: usb_desc_reader

---
 rtl/usb_desc_reader_if.sv | 59 +++++
 rtl/usb_desc_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/usb_desc_reader_if.sv
// rtl/usb_desc_reader_if.sv - request, descriptor ROM map and EP0 TX handshake bundle
interface usb_desc_reader_if;
  logic        i_req;
  logic [15:0] i_wvalue;
  logic [15:0] i_wlength;
  logic        i_hs;
  logic        i_abort;
  logic [15:0] i_desc_dev_addr;
  logic [15:0] i_desc_dev_len;
  logic [15:0] i_desc_qual_addr;
  logic [15:0] i_desc_qual_len;
  logic [15:0] i_desc_fscfg_addr;
  logic [15:0] i_desc_fscfg_len;
  logic [15:0] i_desc_hscfg_addr;
  logic [15:0] i_desc_hscfg_len;
  logic [15:0] i_desc_oscfg_addr;
  logic [15:0] i_desc_strlang_addr;
  logic [15:0] i_desc_strvendor_addr;
  logic [15:0] i_desc_strvendor_len;
  logic [15:0] i_desc_strproduct_addr;
  logic [15:0] i_desc_strproduct_len;
  logic [15:0] i_desc_strserial_addr;
  logic [15:0] i_desc_strserial_len;
  logic        i_descrom_have_strings;
  logic [15:0] o_descrom_raddr;
  logic [7:0]  i_descrom_rdat;
  logic [7:0]  o_txdat;
  logic        o_txval;
  logic        i_txrdy;
  logic        o_txpktend;
  logic        i_pktack;
  logic        o_zlp;
  logic        o_done;
  logic        o_stall;

  modport slave (
    input  i_req, i_wvalue, i_wlength, i_hs, i_abort,
    input  i_desc_dev_addr, i_desc_dev_len, i_desc_qual_addr, i_desc_qual_len,
    input  i_desc_fscfg_addr, i_desc_fscfg_len, i_desc_hscfg_addr, i_desc_hscfg_len,
    input  i_desc_oscfg_addr, i_desc_strlang_addr,
    input  i_desc_strvendor_addr, i_desc_strvendor_len,
    input  i_desc_strproduct_addr, i_desc_strproduct_len,
    input  i_desc_strserial_addr, i_desc_strserial_len,
    input  i_descrom_have_strings, i_descrom_rdat, i_txrdy, i_pktack,
    output o_descrom_raddr, o_txdat, o_txval, o_txpktend, o_zlp, o_done, o_stall
  );

  modport master (
    output i_req, i_wvalue, i_wlength, i_hs, i_abort,
    output i_desc_dev_addr, i_desc_dev_len, i_desc_qual_addr, i_desc_qual_len,
    output i_desc_fscfg_addr, i_desc_fscfg_len, i_desc_hscfg_addr, i_desc_hscfg_len,
    output i_desc_oscfg_addr, i_desc_strlang_addr,
    output i_desc_strvendor_addr, i_desc_strvendor_len,
    output i_desc_strproduct_addr, i_desc_strproduct_len,
    output i_desc_strserial_addr, i_desc_strserial_len,
    output i_descrom_have_strings, i_descrom_rdat, i_txrdy, i_pktack,
    input  o_descrom_raddr, o_txdat, o_txval, o_txpktend, o_zlp, o_done, o_stall
  );
endinterface

// File: rtl/usb_desc_reader.sv
// rtl/usb_desc_reader.sv - EP0 GET_DESCRIPTOR ROM streamer; DESC_OTHER_SPEED_EN enables type 7
module usb_desc_reader #(
  parameter int MAXPKT = 64
) (
  input  logic             CLK,
  input  logic             RESET_N,
  usb_desc_reader_if.slave bus
);

  localparam int         PW       = $clog2(MAXPKT);
  localparam logic [6:0] PKT_LAST = 7'(MAXPKT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_SEND, S_PKTWAIT, S_ZLP, S_STALL
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] wvalue_q, wvalue_d;
  logic [15:0] wlength_q, wlength_d;
  logic        hs_q, hs_d;
  logic [15:0] raddr_q, raddr_d;
  logic [15:0] base_q, base_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] total_q, total_d;
  logic [6:0]  pktcnt_q, pktcnt_d;
  logic        zlp_sent_q, zlp_sent_d;
  logic        os_q, os_d;
  logic        done_q, done_d;

  logic        sel_ok;
  logic        sel_os;
  logic [15:0] sel_base;
  logic [15:0] sel_len;
  logic [16:0] sel_end;
  logic [15:0] sel_eff;
  logic [15:0] offset;
  logic        pkt_end;

  // Decode the latched wValue into a ROM base/length pair.
  always_comb begin
    sel_ok   = 1'b1;
    sel_os   = 1'b0;
    sel_base = '0;
    sel_len  = '0;
    case (wvalue_q[15:8])
      8'h01: begin
        sel_base = bus.i_desc_dev_addr;
        sel_len  = bus.i_desc_dev_len;
      end
      8'h02: begin
        sel_base = hs_q ? bus.i_desc_hscfg_addr : bus.i_desc_fscfg_addr;
        sel_len  = hs_q ? bus.i_desc_hscfg_len  : bus.i_desc_fscfg_len;
      end
      8'h03: begin
        if (!bus.i_descrom_have_strings) begin
          sel_ok = 1'b0;
        end else begin
          case (wvalue_q[7:0])
            8'h00: begin sel_base = bus.i_desc_strlang_addr;    sel_len = 16'd4; end
            8'h01: begin sel_base = bus.i_desc_strvendor_addr;  sel_len = bus.i_desc_strvendor_len; end
            8'h02: begin sel_base = bus.i_desc_strproduct_addr; sel_len = bus.i_desc_strproduct_len; end
            8'h03: begin sel_base = bus.i_desc_strserial_addr;  sel_len = bus.i_desc_strserial_len; end
            default: sel_ok = 1'b0;
          endcase
        end
      end
      8'h06: begin
        sel_base = bus.i_desc_qual_addr;
        sel_len  = bus.i_desc_qual_len;
      end
`ifdef DESC_OTHER_SPEED_EN
      8'h07: begin
        // Other-speed config reuses the opposite-speed config body; only
        // bDescriptorType (offset 1) comes from a separate ROM byte.
        sel_base = hs_q ? bus.i_desc_fscfg_addr : bus.i_desc_hscfg_addr;
        sel_len  = hs_q ? bus.i_desc_fscfg_len  : bus.i_desc_hscfg_len;
        sel_os   = 1'b1;
      end
`endif
      default: sel_ok = 1'b0;
    endcase
  end

  // A descriptor may end exactly at the top of the address space, not beyond.
  assign sel_end = {1'b0, sel_base} + {1'b0, sel_len};
  assign sel_eff = (sel_len < wlength_q) ? sel_len : wlength_q;
  assign offset  = total_q - remaining_q;
  assign pkt_end = (state_q == S_SEND) && ((pktcnt_q == PKT_LAST) || (remaining_q == 16'd1));

  // Transfer sequencing: next state and counter updates; abort overrides all.
  always_comb begin
    state_d     = state_q;
    wvalue_d    = wvalue_q;
    wlength_d   = wlength_q;
    hs_d        = hs_q;
    raddr_d     = raddr_q;
    base_d      = base_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    pktcnt_d    = pktcnt_q;
    zlp_sent_d  = zlp_sent_q;
    os_d        = os_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE, S_STALL: begin
        if (bus.i_req) begin
          wvalue_d  = bus.i_wvalue;
          wlength_d = bus.i_wlength;
          hs_d      = bus.i_hs;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (!sel_ok || (sel_end > 17'h10000)) begin
          state_d = S_STALL;
        end else if (sel_eff == 16'd0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          raddr_d     = sel_base;
          base_d      = sel_base;
          remaining_d = sel_eff;
          total_d     = sel_eff;
          pktcnt_d    = '0;
          zlp_sent_d  = 1'b0;
          os_d        = sel_os;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.i_txrdy) begin
          remaining_d = remaining_q - 16'd1;
          // Hold the address on the final byte so it never wraps past 0xFFFF.
          if (os_q && (offset == 16'd0)) begin
            raddr_d = bus.i_desc_oscfg_addr;
          end else if (remaining_q != 16'd1) begin
            raddr_d = (os_q && (offset == 16'd1)) ? (base_q + 16'd2) : (raddr_q + 16'd1);
          end
          if (pkt_end) begin
            pktcnt_d = '0;
            state_d  = S_PKTWAIT;
          end else begin
            pktcnt_d = pktcnt_q + 7'd1;
          end
        end
      end
      S_PKTWAIT: begin
        if (bus.i_pktack) begin
          if (remaining_q != 16'd0) begin
            state_d = S_SEND;
          end else if (!zlp_sent_q && (total_q[PW-1:0] == '0) && (total_q < wlength_q)) begin
            state_d = S_ZLP;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_ZLP: begin
        if (bus.i_txrdy) begin
          zlp_sent_d = 1'b1;
          state_d    = S_PKTWAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.i_abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      wvalue_q    <= '0;
      wlength_q   <= '0;
      hs_q        <= 1'b0;
      raddr_q     <= '0;
      base_q      <= '0;
      remaining_q <= '0;
      total_q     <= '0;
      pktcnt_q    <= '0;
      zlp_sent_q  <= 1'b0;
      os_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wvalue_q    <= wvalue_d;
      wlength_q   <= wlength_d;
      hs_q        <= hs_d;
      raddr_q     <= raddr_d;
      base_q      <= base_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      pktcnt_q    <= pktcnt_d;
      zlp_sent_q  <= zlp_sent_d;
      os_q        <= os_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_descrom_raddr = raddr_q;
  assign bus.o_txdat         = bus.i_descrom_rdat;
  assign bus.o_txval         = (state_q == S_SEND);
  assign bus.o_txpktend      = pkt_end;
  assign bus.o_zlp           = (state_q == S_ZLP);
  assign bus.o_stall         = (state_q == S_STALL);
  assign bus.o_done          = done_q;

endmodule
